// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: snoops CPU writes to the DMA trigger register, halts the CPU,
// and copies one page of memory into the OAM data port through the mem_ctrl CPU port.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          DMA_LEN       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr_in,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_write_en,
    input  logic        cpu_is_halted,
    output logic        cpu_halt,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_read_en,
    output logic        dma_write_en,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_busy,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HALT_REQ   = 3'd1;
    localparam logic [2:0] S_READ       = 3'd2;
    localparam logic [2:0] S_READ_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE      = 3'd4;
    localparam logic [2:0] S_WRITE_WAIT = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    localparam logic [8:0] LAST_IDX = 9'(DMA_LEN - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_page;
    logic [8:0]  r_idx;
    logic [7:0]  r_dbuf;
    logic        w_trigger;
    logic [15:0] w_src_addr;

    assign w_trigger  = bus_write_en && (bus_addr_in == DMA_REG_ADDR);
    // Only the low index byte forms the offset, so the page never increments.
    assign w_src_addr = {r_page, r_idx[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 9'd0;
            r_dbuf  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page  <= bus_data_in;
                        r_idx   <= 9'd0;
                        r_state <= S_HALT_REQ;
                    end
                end
                S_HALT_REQ: begin
                    if (cpu_is_halted) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (!mem_busy) begin
                        r_dbuf  <= mem_data_in;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state <= S_WRITE_WAIT;
                end
                S_WRITE_WAIT: begin
                    if (!mem_busy) begin
                        r_idx   <= r_idx + 9'd1;
                        r_state <= (r_idx == LAST_IDX) ? S_DONE : S_READ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state alone so reset forces every one of them to zero.
    always_comb begin
        cpu_halt     = 1'b0;
        dma_active   = 1'b0;
        dma_addr     = 16'h0000;
        dma_data_out = 8'h00;
        dma_read_en  = 1'b0;
        dma_write_en = 1'b0;
        dma_done     = 1'b0;
        case (r_state)
            S_HALT_REQ: begin
                cpu_halt = 1'b1;
            end
            S_READ, S_READ_WAIT: begin
                cpu_halt    = 1'b1;
                dma_active  = 1'b1;
                dma_addr    = w_src_addr;
                dma_read_en = (r_state == S_READ);
            end
            S_WRITE, S_WRITE_WAIT: begin
                cpu_halt     = 1'b1;
                dma_active   = 1'b1;
                dma_addr     = OAM_DATA_ADDR;
                dma_data_out = r_dbuf;
                dma_write_en = (r_state == S_WRITE);
            end
            S_DONE: begin
                dma_done = 1'b1;
            end
            default: begin
                cpu_halt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a simple memory model that can stall after each strobe.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_addr_in = 16'h0000;
    logic [7:0]  bus_data_in = 8'h00;
    logic        bus_write_en = 1'b0;
    logic        cpu_is_halted = 1'b1;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_read_en;
    logic        dma_write_en;
    logic [7:0]  mem_data_in;
    logic        mem_busy;
    logic        dma_active;
    logic        dma_done;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int stall = 0;
    int bcnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [7:0]  mem_q = 8'h00;
    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];

    oam_dma_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus_addr_in   (bus_addr_in),
        .bus_data_in   (bus_data_in),
        .bus_write_en  (bus_write_en),
        .cpu_is_halted (cpu_is_halted),
        .cpu_halt      (cpu_halt),
        .dma_addr      (dma_addr),
        .dma_data_out  (dma_data_out),
        .dma_read_en   (dma_read_en),
        .dma_write_en  (dma_write_en),
        .mem_data_in   (mem_data_in),
        .mem_busy      (mem_busy),
        .dma_active    (dma_active),
        .dma_done      (dma_done)
    );

    always #5 clk = ~clk;

    // Memory model: source byte at {pg,i} is i ^ 5A ^ pg ^ 03; data is garbage while busy.
    assign mem_busy    = (bcnt != 0);
    assign mem_data_in = mem_busy ? 8'hEE : mem_q;

    function automatic logic [7:0] exp_byte(input logic [7:0] pg, input int i);
        logic [7:0] lo;
        lo = i[7:0];
        return lo ^ 8'h5A ^ pg ^ 8'h03;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dma_read_en) begin
            rd_q.push_back(dma_addr);
            mem_q <= dma_addr[7:0] ^ 8'h5A ^ dma_addr[15:8] ^ 8'h03;
        end
        if (dma_write_en) begin
            wa_q.push_back(dma_addr);
            wd_q.push_back(dma_data_out);
        end
        if (dma_read_en || dma_write_en) bcnt <= stall;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (dma_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic trigger(input logic [7:0] pg, output int t0);
        bus_addr_in  = 16'h4014;
        bus_data_in  = pg;
        bus_write_en = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus_write_en = 1'b0;
        bus_addr_in  = 16'h0000;
        bus_data_in  = 8'h00;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (done_cnt != d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done, dma_addr, dma_data_out} !== 29'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done, dma_addr, dma_data_out});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_trigger();
        clear_logs();
        bus_addr_in = 16'h4014; bus_data_in = 8'h03; bus_write_en = 1'b0;
        @(negedge clk);
        bus_addr_in = 16'h4015; bus_write_en = 1'b1;
        @(negedge clk);
        bus_addr_in = 16'h0000; bus_write_en = 1'b0;
        repeat (5) @(negedge clk);
        nvec++;
        if (cpu_halt !== 1'b0 || rd_q.size() != 0) begin
            nerr++;
            $display("FAIL no_trigger: cpu_halt=%b reads=%0d want 0/0", cpu_halt, rd_q.size());
        end
    endtask

    task automatic test_basic();
        int t0;
        bit ok;
        clear_logs();
        cpu_is_halted = 1'b1;
        stall = 0;
        trigger(8'h03, t0);
        nvec++;
        if ({cpu_halt, dma_active, dma_read_en} !== 3'b100) begin
            nerr++;
            $display("FAIL basic_halt_req: got %b want 100", {cpu_halt, dma_active, dma_read_en});
        end
        wait_done(1200, ok);
        nvec++;
        if (!ok || done_cyc != t0 + 1026) begin
            nerr++;
            $display("FAIL basic_done_cycle: ok=%0d got T+%0d want T+1026", ok, done_cyc - t0);
        end
        nvec++;
        if (rd_q.size() != 256 || wa_q.size() != 256) begin
            nerr++;
            $display("FAIL basic_count: reads=%0d writes=%0d want 256", rd_q.size(), wa_q.size());
        end
        for (int i = 0; i < 256 && i < rd_q.size() && i < wa_q.size(); i++) begin
            nvec++;
            if ({rd_q[i], wa_q[i], wd_q[i]} !== {16'h0300 + 16'(i), 16'h2004, exp_byte(8'h03, i)}) begin
                nerr++;
                $display("FAIL basic_byte%0d: got rd=%h wa=%h wd=%h want rd=%h wa=2004 wd=%h",
                         i, rd_q[i], wa_q[i], wd_q[i], 16'h0300 + 16'(i), exp_byte(8'h03, i));
            end
        end
        nvec++;
        if ({cpu_halt, dma_active} !== 2'b00) begin
            nerr++;
            $display("FAIL basic_release: halt/active=%b want 00", {cpu_halt, dma_active});
        end
    endtask

    task automatic test_halt_delay();
        int t0;
        bit ok;
        bit bad;
        clear_logs();
        cpu_is_halted = 1'b0;
        trigger(8'h03, t0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cpu_halt !== 1'b1 || dma_read_en !== 1'b0 || rd_q.size() != 0) bad = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL halt_wait: cpu_halt dropped or strobe seen while unacknowledged");
        end
        cpu_is_halted = 1'b1;
        nvec++;
        if ({cpu_halt, dma_read_en} !== 2'b10) begin
            nerr++;
            $display("FAIL halt_ack_cycle: halt/read=%b want 10", {cpu_halt, dma_read_en});
        end
        @(negedge clk);
        nvec++;
        if ({dma_read_en, dma_addr} !== {1'b1, 16'h0300}) begin
            nerr++;
            $display("FAIL halt_first_read: rd=%b addr=%h want 1/0300", dma_read_en, dma_addr);
        end
        wait_done(1200, ok);
        nvec++;
        if (!ok || done_cyc != t0 + 1046 || rd_q.size() != 256) begin
            nerr++;
            $display("FAIL halt_done_cycle: ok=%0d got T+%0d reads=%0d want T+1046/256",
                     ok, done_cyc - t0, rd_q.size());
        end
    endtask

    task automatic test_stall();
        int t0;
        bit ok;
        clear_logs();
        stall = 3;
        trigger(8'h03, t0);
        wait_done(3000, ok);
        stall = 0;
        nvec++;
        if (!ok || done_cyc != t0 + 2562) begin
            nerr++;
            $display("FAIL stall_done_cycle: ok=%0d got T+%0d want T+2562", ok, done_cyc - t0);
        end
        nvec++;
        if (wd_q.size() != 256) begin
            nerr++;
            $display("FAIL stall_count: writes=%0d want 256", wd_q.size());
        end
        for (int i = 0; i < 256 && i < wd_q.size(); i++) begin
            nvec++;
            if (wd_q[i] !== exp_byte(8'h03, i)) begin
                nerr++;
                $display("FAIL stall_byte%0d: got %h want %h", i, wd_q[i], exp_byte(8'h03, i));
            end
        end
    endtask

    task automatic test_mid_write();
        int t0;
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt;
        trigger(8'h02, t0);
        repeat (50) @(negedge clk);
        bus_addr_in = 16'h4014; bus_data_in = 8'h05; bus_write_en = 1'b1;
        @(negedge clk);
        bus_write_en = 1'b0; bus_addr_in = 16'h0000; bus_data_in = 8'h00;
        wait_done(1200, ok);
        for (int i = 0; i < 256 && i < rd_q.size(); i++) begin
            nvec++;
            if (rd_q[i] !== 16'h0200 + 16'(i)) begin
                nerr++;
                $display("FAIL mid_src%0d: got %h want %h", i, rd_q[i], 16'h0200 + 16'(i));
            end
        end
        repeat (20) @(negedge clk);
        nvec++;
        if (!ok || cpu_halt !== 1'b0 || rd_q.size() != 256 || done_cnt != d0 + 1) begin
            nerr++;
            $display("FAIL mid_no_requeue: ok=%0d halt=%b reads=%0d dones=%0d want 1/0/256/1",
                     ok, cpu_halt, rd_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_page_ff();
        int t0;
        int zeros;
        bit ok;
        clear_logs();
        trigger(8'hFF, t0);
        wait_done(1200, ok);
        nvec++;
        if (!ok || rd_q.size() != 256 || rd_q[rd_q.size() - 1] !== 16'hFFFF) begin
            nerr++;
            $display("FAIL pageff_last: ok=%0d reads=%0d last=%h want 256/FFFF",
                     ok, rd_q.size(), (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] : 16'h0);
        end
        zeros = 0;
        foreach (rd_q[i]) if (rd_q[i][15:8] !== 8'hFF) zeros++;
        nvec++;
        if (zeros != 0) begin
            nerr++;
            $display("FAIL pageff_wrap: %0d reads outside page FF want 0", zeros);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        bit seen;
        bit bad;
        clear_logs();
        trigger(8'h03, t0);
        seen = 1'b0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            @(negedge clk);
            if (dma_done === 1'b1) seen = 1'b1;
        end
        nvec++;
        if (!seen) begin
            nerr++;
            $display("FAIL b2b_done_seen: no dma_done within 1200 cycles");
        end
        bus_addr_in = 16'h4014; bus_data_in = 8'h04; bus_write_en = 1'b1;
        @(negedge clk);
        bus_write_en = 1'b0; bus_addr_in = 16'h0000; bus_data_in = 8'h00;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (cpu_halt !== 1'b0 || dma_done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if (bad || rd_q.size() != 256) begin
            nerr++;
            $display("FAIL b2b_ignored: trigger at DONE started work (reads=%0d want 256)", rd_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int d0;
        bit ok;
        bit hit;
        clear_logs();
        trigger(8'h03, t0);
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(negedge clk);
            if (rd_q.size() == 101) hit = 1'b1;
        end
        nvec++;
        if (!hit || {dma_read_en, dma_addr} !== {1'b0, 16'h0364}) begin
            nerr++;
            $display("FAIL rstmid_wait_state: hit=%0d rd=%b addr=%h want 1/0/0364", hit, dma_read_en, dma_addr);
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done, dma_addr, dma_data_out} !== 29'd0) begin
            nerr++;
            $display("FAIL rstmid_outputs: got %h want 0",
                     {cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done, dma_addr, dma_data_out});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (done_cnt != d0 || cpu_halt !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_no_done: dones=%0d halt=%b want 0/0", done_cnt - d0, cpu_halt);
        end
        clear_logs();
        trigger(8'h03, t0);
        wait_done(1200, ok);
        nvec++;
        if (!ok || done_cyc != t0 + 1026 || rd_q.size() != 256 || rd_q[0] !== 16'h0300) begin
            nerr++;
            $display("FAIL rstmid_restart: ok=%0d T+%0d reads=%0d first=%h want T+1026/256/0300",
                     ok, done_cyc - t0, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'h0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_no_trigger();
        test_basic();
        test_halt_delay();
        test_stall();
        test_mid_write();
        test_page_ff();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
